// File: rtl/adsr_pkg.sv
// adsr_pkg: state encodings and velocity width for the ADSR envelope.
// The encodings are shared with the LED debug decode.
package adsr_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_e;

  localparam int VEL_W = 7;

endpackage

// File: rtl/adsr_rate_tick.sv
// adsr_rate_tick: per-stage prescaler, ticks when count reaches rate.
// A rate of 0 gives a tick every enabled cycle.
module adsr_rate_tick #(
  parameter int RATE_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] cnt;

  assign tick = en && (cnt >= rate);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + RATE_W'(1);
    end
  end

endmodule

// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope with retrigger, legato release and done pulse.
// ADSR_VELOCITY_EN adds a registered velocity-scaled output stage.
module adsr_env
  import adsr_pkg::*;
#(
  parameter int LEVEL_W = 16,
  parameter int RATE_W  = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gate,
  input  logic               retrigger,
  input  logic [RATE_W-1:0]  attack_rate,
  input  logic [RATE_W-1:0]  decay_rate,
  input  logic [RATE_W-1:0]  release_rate,
  input  logic [LEVEL_W-1:0] attack_level,
  input  logic [LEVEL_W-1:0] sustain_level,
`ifdef ADSR_VELOCITY_EN
  input  logic [VEL_W-1:0]   velocity,
`endif
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         state,
  output logic               active,
  output logic               done
);

  typedef struct packed {
    logic [LEVEL_W-1:0] a_lvl;
    logic [LEVEL_W-1:0] s_lvl;
    logic [RATE_W-1:0]  a_rate;
    logic [RATE_W-1:0]  d_rate;
    logic [RATE_W-1:0]  r_rate;
  } cfg_t;

  cfg_t               cfg;
  adsr_state_e        st, nst;
  logic [LEVEL_W-1:0] lvl, nlvl;
  logic [RATE_W-1:0]  rate;
  logic               load, fin, done_r;
  logic               en, tick, clr;

  always_comb begin
    rate = '0;
    en   = 1'b0;
    unique case (st)
      ATTACK:  begin rate = cfg.a_rate; en = 1'b1; end
      DECAY:   begin rate = cfg.d_rate; en = 1'b1; end
      RELEASE: begin rate = cfg.r_rate; en = 1'b1; end
      default: ;
    endcase
  end

  assign clr = load | (nst != st);

  adsr_rate_tick #(
    .RATE_W(RATE_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .rate  (rate),
    .tick  (tick)
  );

  // Gate low beats retrigger, which beats stage completion.
  always_comb begin
    nst  = st;
    nlvl = lvl;
    load = 1'b0;
    fin  = 1'b0;
    unique case (st)
      OFF: begin
        if (gate) begin
          nst  = ATTACK;
          load = 1'b1;
        end
      end
      ATTACK: begin
        if (!gate) nst = RELEASE;
        else if (retrigger) load = 1'b1;
        else if (lvl >= cfg.a_lvl) nst = DECAY;
        else if (tick) nlvl = lvl + LEVEL_W'(1);
      end
      DECAY: begin
        if (!gate) nst = RELEASE;
        else if (retrigger) begin
          nst  = ATTACK;
          load = 1'b1;
        end else if (lvl <= cfg.s_lvl) begin
          nst  = SUSTAIN;
          nlvl = cfg.s_lvl;
        end else if (tick) nlvl = lvl - LEVEL_W'(1);
      end
      SUSTAIN: begin
        if (!gate) nst = RELEASE;
        else if (retrigger) begin
          nst  = ATTACK;
          load = 1'b1;
        end
      end
      RELEASE: begin
        if (gate) begin
          nst  = ATTACK;
          load = 1'b1;
        end else if (lvl == '0) begin
          nst = OFF;
          fin = 1'b1;
        end else if (tick) nlvl = lvl - LEVEL_W'(1);
      end
      default: nst = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= OFF;
      lvl    <= '0;
      cfg    <= '0;
      done_r <= 1'b0;
    end else begin
      st     <= nst;
      lvl    <= nlvl;
      done_r <= fin;
      if (load) begin
        cfg.a_lvl  <= attack_level;
        cfg.s_lvl  <= (sustain_level > attack_level) ?
                      attack_level : sustain_level;
        cfg.a_rate <= attack_rate;
        cfg.d_rate <= decay_rate;
        cfg.r_rate <= release_rate;
      end
    end
  end

`ifdef ADSR_VELOCITY_EN
  localparam int PW = LEVEL_W + VEL_W + 1;

  logic [VEL_W-1:0]   vel;
  logic [VEL_W:0]     vmul;
  logic [PW-1:0]      prod;
  logic [LEVEL_W-1:0] o_lvl;
  adsr_state_e        o_st;
  logic               o_done;

  assign vmul = {1'b0, vel} + (VEL_W+1)'(1);
  assign prod = PW'(lvl) * PW'(vmul);

  always_ff @(posedge clk) begin
    if (reset) begin
      vel    <= '0;
      o_lvl  <= '0;
      o_st   <= OFF;
      o_done <= 1'b0;
    end else begin
      if (load) vel <= velocity;
      o_lvl  <= prod[VEL_W +: LEVEL_W];
      o_st   <= st;
      o_done <= done_r;
    end
  end

  assign level  = o_lvl;
  assign state  = o_st;
  assign active = (o_st != OFF);
  assign done   = o_done;
`else
  assign level  = lvl;
  assign state  = st;
  assign active = (st != OFF);
  assign done   = done_r;
`endif

endmodule

// File: doc/adsr_env.md
Name: adsr_env

Overview:
Parametrised successor to the synth's ADSR envelope generator. All rates and levels are runtime inputs, and the level width is a parameter. Adds retrigger without a click, legato re-attack from release, and a done pulse. It sits between the MIDI note decoder (gate/retrigger) and the oscillator-amplitude multiplier in the mclk audio domain.

Parameters:
LEVEL_W, 16, width of the envelope level and of all level inputs
RATE_W, 24, width of the per-stage rate (clock cycles per level step)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
gate  in  1  note held (level-sensitive)
retrigger  in  1  one-cycle pulse; restarts attack while gate=1
attack_rate  in  RATE_W  cycles per +1 step in ATTACK
decay_rate  in  RATE_W  cycles per -1 step in DECAY
release_rate  in  RATE_W  cycles per -1 step in RELEASE
attack_level  in  LEVEL_W  peak level
sustain_level  in  LEVEL_W  hold level
velocity  in  7  note velocity (present only with ADSR_VELOCITY_EN)
level  out  LEVEL_W  envelope output
state  out  3  OFF=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
active  out  1  state != OFF
done  out  1  one-cycle pulse on RELEASE->OFF

Behaviour:
- One clock `clk`; reset is synchronous and active-high (`reset`). Reset takes effect at any time, including mid-envelope: level=0, state=OFF, active=0, done=0, prescaler=0, and the config snapshot is cleared.
- Config snapshot: attack_level, sustain_level and the three rates are latched on every entry to ATTACK. Input changes take effect only at the next entry to ATTACK. If sustain_level > attack_level, the latched sustain value is clamped to attack_level.
- Prescaler: counts clock cycles while in ATTACK, DECAY or RELEASE. A tick fires when count >= the current stage's latched rate; on a tick the count returns to 0. Rate 0 gives a tick every cycle. The count clears on every state change.
- Transitions (gate falling has the highest priority, then retrigger, then stage completion):
  - OFF: gate=1 -> ATTACK; level stays 0.
  - ATTACK: on a tick, level+1, saturating at the latched attack_level. When level == attack_level -> DECAY. A latched attack_level of 0 goes to DECAY the cycle after entry.
  - DECAY: on a tick, level-1. When level <= latched sustain -> SUSTAIN, with level forced to the latched sustain.
  - SUSTAIN: level holds.
  - From A/D/S: gate=0 -> RELEASE. If gate falls in the same cycle a stage completes, the state goes to RELEASE.
  - RELEASE: on a tick, level-1. When level==0 -> OFF and done=1 for one cycle. gate=1 in RELEASE -> ATTACK from the current level (legato, no jump to 0).
  - retrigger=1 with gate=1 in DECAY/SUSTAIN/ATTACK -> ATTACK from the current level and re-latch the config. retrigger is ignored when gate=0.
- Level never wraps: increments saturate at the latched attack_level, decrements saturate at 0.
- Outputs are registered. level/state update in the cycle after the triggering clock edge.

Optional Feature:
ADSR_VELOCITY_EN
- Defined: the `velocity` port exists and is latched with the config snapshot. The output is level_out = (level_raw * (velocity+1)) >> 7, registered, adding one cycle of latency to `level`. state/active/done are delayed by one cycle to stay aligned with it.
- Undefined: the port is absent, level_out = level_raw, and there is no extra latency.

Decomposition:
- Package adsr_pkg: the 3-bit state encoding constants OFF/ATTACK/DECAY/SUSTAIN/RELEASE, and the velocity width (7). These encodings are shared with the top-level LED debug decode.
- Sub-module adsr_rate_tick: the RATE_W prescaler with clear, enable and rate inputs and a tick output. It is instantiated once and muxed by state.

Test Plan:
- Reset mid-DECAY at level 700 -> next cycle level=0, state=0, active=0; prescaler restarts from 0 on the next gate.
- Config attack_rate=2, attack_level=10, decay_rate=0, sustain_level=4, gate=1 held -> level reaches 10 after 30 cycles, state=DECAY, then 4 after 6 more cycles with state=SUSTAIN, then holds.
- Gate drops in SUSTAIN at level 4 with release_rate=0 -> RELEASE, level 3,2,1,0 on consecutive cycles, then OFF; done=1 for exactly one cycle.
- Gate drops in the same cycle ATTACK reaches attack_level -> state=RELEASE, not DECAY.
- Gate reasserted in RELEASE at level 5 -> ATTACK resumes from 5; level never drops below 5.
- ADSR_VELOCITY_EN, velocity=63, sustain level 512 -> output 256 with one extra cycle of latency; sustain_level=2000 > attack_level=1000 -> sustain clamped to 1000, DECAY exits immediately.
